// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: turns resolved execute jumps into a flushed,
// drained, handshaked fetch redirect and counts completed redirects.
// Ports: clk/reset (sync, active-high); execute_done, jump_signal,
//   jump_target, jump_pc from execute; fetch_busy, fetch_ack from fetch;
//   trap_ack from the trap handler; jump_ready, stall_front, flush_front,
//   redirect_valid/redirect_pc to the front-end; trap_valid/trap_pc/
//   trap_tval to the trap handler; redirect_count; sticky proto_err.
// Option: define REDIRECT_MISALIGN_CHECK_EN to trap on targets with
//   bit 1 set instead of redirecting to them.
module branch_redirect_unit #(
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              execute_done,
   input  logic              jump_signal,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] jump_pc,
   input  logic              fetch_busy,
   input  logic              fetch_ack,
   input  logic              trap_ack,
   output logic              jump_ready,
   output logic              stall_front,
   output logic              flush_front,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              trap_valid,
   output logic [ADDR_W-1:0] trap_pc,
   output logic [ADDR_W-1:0] trap_tval,
   output logic [CNT_W-1:0]  redirect_count,
   output logic              proto_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      ISSUE = 2'd2,
      TRAP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] tgt_q;
   logic              flush_q;
   logic [CNT_W-1:0]  count_q;
   logic              perr_q;
   logic              jump;
   logic              accept;
   logic [ADDR_W-1:0] cap_tgt;

   assign jump    = execute_done && jump_signal;
   assign accept  = jump && (state == IDLE);
   // Bit 0 is forced clear for every target (JALR rule).
   assign cap_tgt = {jump_target[ADDR_W-1:1], 1'b0};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef REDIRECT_MISALIGN_CHECK_EN
               if (cap_tgt[1])
                  state_nx = TRAP;
               else
`endif
               if (fetch_busy)
                  state_nx = DRAIN;
               else
                  state_nx = ISSUE;
            end
         end
         DRAIN: begin
            if (!fetch_busy)
               state_nx = ISSUE;
         end
         ISSUE: begin
            if (fetch_ack)
               state_nx = IDLE;
         end
`ifdef REDIRECT_MISALIGN_CHECK_EN
         TRAP: begin
            if (trap_ack)
               state_nx = IDLE;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         tgt_q   <= '0;
         flush_q <= 1'b0;
         count_q <= '0;
         perr_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         flush_q <= accept;
         if (accept)
            tgt_q <= cap_tgt;
         if (state == ISSUE && fetch_ack)
            count_q <= count_q + 1'b1;
         // A jump arriving while busy is dropped but remembered as an error.
         if (jump && state != IDLE)
            perr_q <= 1'b1;
      end
   end

   assign jump_ready     = (state == IDLE);
   assign stall_front    = (state != IDLE);
   assign flush_front    = flush_q;
   assign redirect_valid = (state == ISSUE);
   assign redirect_pc    = tgt_q;
   assign redirect_count = count_q;
   assign proto_err      = perr_q;

`ifdef REDIRECT_MISALIGN_CHECK_EN
   logic [ADDR_W-1:0] pc_q;
   logic              unused_ok;

   always_ff @(posedge clk) begin
      if (reset)
         pc_q <= '0;
      else if (accept)
         pc_q <= jump_pc;
   end

   assign trap_valid = (state == TRAP);
   assign trap_pc    = pc_q;
   assign trap_tval  = tgt_q;
   assign unused_ok  = jump_target[0];
`else
   logic unused_ok;

   assign trap_valid = 1'b0;
   assign trap_pc    = '0;
   assign trap_tval  = '0;
   assign unused_ok  = ^{trap_ack, jump_pc, jump_target[0]};
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit.
// Inputs change 1 time unit after the rising edge; outputs checked there.
module tb_branch_redirect_unit;

   localparam int AW = 64;
   localparam int CW = 32;

   logic          clk;
   logic          reset;
   logic          execute_done;
   logic          jump_signal;
   logic [AW-1:0] jump_target;
   logic [AW-1:0] jump_pc;
   logic          fetch_busy;
   logic          fetch_ack;
   logic          trap_ack;
   logic          jump_ready;
   logic          stall_front;
   logic          flush_front;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          trap_valid;
   logic [AW-1:0] trap_pc;
   logic [AW-1:0] trap_tval;
   logic [CW-1:0] redirect_count;
   logic          proto_err;

   int passed = 0;
   int total  = 0;

   branch_redirect_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk),
      .reset(reset),
      .execute_done(execute_done),
      .jump_signal(jump_signal),
      .jump_target(jump_target),
      .jump_pc(jump_pc),
      .fetch_busy(fetch_busy),
      .fetch_ack(fetch_ack),
      .trap_ack(trap_ack),
      .jump_ready(jump_ready),
      .stall_front(stall_front),
      .flush_front(flush_front),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .trap_valid(trap_valid),
      .trap_pc(trap_pc),
      .trap_tval(trap_tval),
      .redirect_count(redirect_count),
      .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic present(input logic [AW-1:0] tgt, input logic [AW-1:0] pc);
      execute_done = 1'b1;
      jump_signal  = 1'b1;
      jump_target  = tgt;
      jump_pc      = pc;
   endtask

   task automatic clear_jump();
      execute_done = 1'b0;
      jump_signal  = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      execute_done = 1'b0;
      jump_signal  = 1'b0;
      jump_target  = '0;
      jump_pc      = '0;
      fetch_busy   = 1'b0;
      fetch_ack    = 1'b0;
      trap_ack     = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("rst_ready", 64'(jump_ready), 64'd1);
      chk("rst_stall", 64'(stall_front), 64'd0);
      chk("rst_flush", 64'(flush_front), 64'd0);
      chk("rst_rv", 64'(redirect_valid), 64'd0);
      chk("rst_rpc", redirect_pc, 64'd0);
      chk("rst_cnt", 64'(redirect_count), 64'd0);
      chk("rst_perr", 64'(proto_err), 64'd0);
      chk("rst_trap", 64'(trap_valid), 64'd0);

      // Basic redirect, fetch idle
      present(64'h1000, 64'h0ff0);
      step();
      clear_jump();
      chk("bas_flush", 64'(flush_front), 64'd1);
      chk("bas_stall", 64'(stall_front), 64'd1);
      chk("bas_ready", 64'(jump_ready), 64'd0);
      chk("bas_rv", 64'(redirect_valid), 64'd1);
      chk("bas_rpc", redirect_pc, 64'h1000);
      fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
      chk("bas_ready2", 64'(jump_ready), 64'd1);
      chk("bas_flush2", 64'(flush_front), 64'd0);
      chk("bas_rv2", 64'(redirect_valid), 64'd0);
      chk("bas_cnt", 64'(redirect_count), 64'd1);

      // Drain: busy at N, N+1, N+2
      present(64'h2004, 64'h1ff0);
      fetch_busy = 1'b1;
      step();
      clear_jump();
      chk("drn_flush1", 64'(flush_front), 64'd1);
      chk("drn_rv1", 64'(redirect_valid), 64'd0);
      chk("drn_stall1", 64'(stall_front), 64'd1);
      step();
      chk("drn_flush2", 64'(flush_front), 64'd0);
      chk("drn_rv2", 64'(redirect_valid), 64'd0);
      chk("drn_stall2", 64'(stall_front), 64'd1);
      step();
      fetch_busy = 1'b0;
      chk("drn_rv3", 64'(redirect_valid), 64'd0);
      chk("drn_stall3", 64'(stall_front), 64'd1);
      step();
      chk("drn_rv4", 64'(redirect_valid), 64'd1);
      chk("drn_rpc", redirect_pc, 64'h2004);
      chk("drn_stall4", 64'(stall_front), 64'd1);
      step();
      chk("drn_hold", 64'(redirect_valid), 64'd1);
      fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
      chk("drn_cnt", 64'(redirect_count), 64'd2);
      chk("drn_ready", 64'(jump_ready), 64'd1);

      // JALR bit-0 clear
      present(64'h3001, 64'h2ff0);
      step();
      clear_jump();
      chk("jalr_rpc", redirect_pc, 64'h3000);
      fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
      chk("jalr_cnt", 64'(redirect_count), 64'd3);

      // Non-jump result and stray ack in IDLE are ignored
      execute_done = 1'b1;
      fetch_ack    = 1'b1;
      step();
      execute_done = 1'b0;
      fetch_ack    = 1'b0;
      chk("ign_ready", 64'(jump_ready), 64'd1);
      chk("ign_flush", 64'(flush_front), 64'd0);
      chk("ign_cnt", 64'(redirect_count), 64'd3);

      // Protocol violation while ISSUE awaits ack
      present(64'h4000, 64'h3ff0);
      step();
      present(64'h5000, 64'h4ff0);
      step();
      clear_jump();
      chk("pv_rpc", redirect_pc, 64'h4000);
      chk("pv_rv", 64'(redirect_valid), 64'd1);
      chk("pv_perr", 64'(proto_err), 64'd1);
      chk("pv_flush", 64'(flush_front), 64'd0);
      fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
      chk("pv_cnt", 64'(redirect_count), 64'd4);
      step();
      chk("pv_sticky", 64'(proto_err), 64'd1);
      chk("pv_idle_rv", 64'(redirect_valid), 64'd0);

      // Reset mid-DRAIN
      present(64'h7000, 64'h6ff0);
      fetch_busy = 1'b1;
      step();
      clear_jump();
      chk("rd_stall", 64'(stall_front), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rd_ready", 64'(jump_ready), 64'd1);
      chk("rd_stall0", 64'(stall_front), 64'd0);
      chk("rd_flush", 64'(flush_front), 64'd0);
      chk("rd_rv", 64'(redirect_valid), 64'd0);
      chk("rd_rpc", redirect_pc, 64'd0);
      chk("rd_cnt", 64'(redirect_count), 64'd0);
      chk("rd_perr", 64'(proto_err), 64'd0);
      fetch_busy = 1'b0;
      step();
      step();
      chk("rd_norv", 64'(redirect_valid), 64'd0);
      chk("rd_ready2", 64'(jump_ready), 64'd1);

      // Misaligned target
      present(64'h6002, 64'h5ff0);
      step();
      clear_jump();
      chk("mis_flush", 64'(flush_front), 64'd1);
`ifdef REDIRECT_MISALIGN_CHECK_EN
      chk("mis_tv", 64'(trap_valid), 64'd1);
      chk("mis_tpc", trap_pc, 64'h5ff0);
      chk("mis_tval", trap_tval, 64'h6002);
      chk("mis_rv", 64'(redirect_valid), 64'd0);
      fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
      chk("mis_hold", 64'(trap_valid), 64'd1);
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
      chk("mis_ready", 64'(jump_ready), 64'd1);
      chk("mis_tv0", 64'(trap_valid), 64'd0);
      chk("mis_rv0", 64'(redirect_valid), 64'd0);
      chk("mis_cnt", 64'(redirect_count), 64'd0);
`else
      chk("mis_tv", 64'(trap_valid), 64'd0);
      chk("mis_rv", 64'(redirect_valid), 64'd1);
      chk("mis_rpc", redirect_pc, 64'h6002);
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
      chk("mis_tack", 64'(redirect_valid), 64'd1);
      fetch_ack = 1'b1;
      step();
      fetch_ack = 1'b0;
      chk("mis_ready", 64'(jump_ready), 64'd1);
      chk("mis_cnt", 64'(redirect_count), 64'd1);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Consumes the execute stage's resolved-jump output (done strobe, jump flag, computed target) and turns it into a fetch redirect. Sits between execute and fetch. Flushes the wrong-path front-end, stalls execute while a redirect is pending, waits for any in-flight fetch to drain, then hands the corrected PC to fetch with a valid/ack handshake. Also keeps a redirect performance counter.

## Interface
Parameters:
- ADDR_W, 64, PC/target width
- CNT_W, 32, redirect counter width

Ports:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- execute_done  in  1  execute result valid this cycle
- jump_signal  in  1  resolved instruction redirects control flow (taken branch, JAL, JALR)
- jump_target  in  ADDR_W  computed target from execute
- jump_pc  in  ADDR_W  PC of the jumping instruction
- fetch_busy  in  1  fetch has an outstanding I-cache request
- fetch_ack  in  1  fetch accepted redirect_pc this cycle
- trap_ack  in  1  trap handler accepted trap (used only with REDIRECT_MISALIGN_CHECK_EN)
- jump_ready  out  1  unit is IDLE and can accept a jump
- stall_front  out  1  hold fetch/decode/execute
- flush_front  out  1  one-cycle kill of IF/ID and ID/EX contents
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  ADDR_W  new fetch PC
- trap_valid  out  1  misaligned-target trap pending
- trap_pc  out  ADDR_W  jump_pc of the faulting instruction
- trap_tval  out  ADDR_W  faulting target
- redirect_count  out  CNT_W  completed redirects, wraps modulo 2^CNT_W
- proto_err  out  1  sticky: jump presented while jump_ready=0

## Operation
- Accept condition: execute_done && jump_signal && state==IDLE.
- Target register: captures {jump_target[ADDR_W-1:1], 1'b0}. Bit 0 is always cleared, which gives the JALR rule. jump_pc is captured alongside.
- FSM states: IDLE, DRAIN, ISSUE, TRAP.
  - IDLE -> TRAP on accept when the misalign check is enabled and the captured target bit 1 = 1.
  - Otherwise, on accept: IDLE -> DRAIN if fetch_busy=1, else IDLE -> ISSUE.
  - DRAIN -> ISSUE on the first cycle fetch_busy=0.
  - ISSUE -> IDLE when fetch_ack=1. redirect_count increments on that edge.
  - TRAP -> IDLE when trap_ack=1. The counter does not increment.
- jump_ready = (state==IDLE). stall_front = (state!=IDLE).
- flush_front is a registered one-cycle pulse on the cycle after accept. It fires for both redirect and trap.
- redirect_valid = (state==ISSUE). redirect_pc holds the captured target and stays stable until ack.
- trap_valid = (state==TRAP). trap_pc and trap_tval are stable while trap_valid is high.
- execute_done=1 with jump_signal=0 is ignored in every state.
- Jump presented while not IDLE:
  - It is dropped and the pending redirect is unaffected.
  - proto_err sets and stays set until reset.
- fetch_ack outside ISSUE is ignored. trap_ack outside TRAP is ignored.
- Reset, including mid-operation, forces the following on the next edge; any pending redirect is discarded:
  - state = IDLE
  - all outputs 0, except jump_ready=1
  - redirect_count = 0, proto_err = 0
  - captured target and PC = 0

## Timing
- Accept at cycle N.
  - flush_front=1 and stall_front=1 in cycle N+1.
  - If fetch_busy=0 at N: redirect_valid=1 in N+1.
- Minimum loop: accept at N, redirect_valid and fetch_ack at N+1, jump_ready=1 at N+2. That is two cycles per redirect.
- DRAIN adds one cycle per cycle fetch_busy stays high after N. ISSUE starts on the edge after fetch_busy is sampled low.
- redirect_valid stays high for an unbounded time until fetch_ack. There is no timeout.
- redirect_count updates on the edge where ISSUE && fetch_ack.
- No combinational path from the inputs to redirect_valid, redirect_pc, trap_*, or flush_front.
- jump_ready and stall_front are state decodes only.

## Configuration
- `REDIRECT_MISALIGN_CHECK_EN` defined:
  - A captured target with bit 1 set enters TRAP instead of DRAIN/ISSUE.
  - trap_tval = the captured target, with bit 0 already cleared.
  - No redirect is issued for that jump.
- Undefined:
  - The TRAP state is not built.
  - trap_valid, trap_pc and trap_tval are tied to 0 and trap_ack is ignored.
  - Targets with bit 1 set redirect normally.

## Test plan
- Basic redirect:
  - Stimulus: jump_target=0x1000, fetch_busy=0, fetch_ack high whenever redirect_valid.
  - Required: flush_front one cycle at N+1, redirect_pc=0x1000 at N+1, jump_ready back at N+2, redirect_count=1.
- Drain:
  - Stimulus: jump_target=0x2004, fetch_busy high for 3 cycles after accept.
  - Required: redirect_valid first at N+4, stall_front high N+1..ack.
- JALR LSB clear:
  - Stimulus: jump_target=0x3001.
  - Required: redirect_pc=0x3000.
- Protocol violation:
  - Stimulus: second jump to 0x5000 while ISSUE awaits ack for 0x4000.
  - Required: redirect_pc stays 0x4000, proto_err=1 sticky, count=1 after ack.
- Reset mid-DRAIN:
  - Stimulus: reset=1 for one cycle with fetch_busy held.
  - Required: next cycle all outputs 0, jump_ready=1, count=0, no redirect_valid after fetch_busy drops.
- Misaligned target:
  - Stimulus: jump_target=0x6002, jump_pc=0x5FF0.
  - Required with macro: trap_valid=1, trap_pc=0x5FF0, trap_tval=0x6002, no redirect_valid, count unchanged after trap_ack.
  - Required without macro: redirect_pc=0x6002.
